// File: rtl/branch_pc_unit_pkg.sv
// Purpose: shared types, defaults and helpers for the branch/PC unit.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package branch_pc_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF     = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEF      = 4;
    localparam int unsigned OFFSET_SHIFT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FLAG = 2'd1,
        REDIRECT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BT_NONE = 2'd0,
        BT_EQ   = 2'd1,
        BT_NE   = 2'd2
    } bt_t;

    // BEQ and BNE together is not a legal encoding; it decodes to "no branch",
    // which makes it behave as not-taken.
    function automatic bt_t decode_bt(input logic branch_eq, input logic branch_ne);
        bt_t bt;
        bt = BT_NONE;
        if (branch_eq && !branch_ne) begin
            bt = BT_EQ;
        end else if (branch_ne && !branch_eq) begin
            bt = BT_NE;
        end
        return bt;
    endfunction

    function automatic logic branch_taken(input bt_t bt, input logic zero);
        return ((bt == BT_EQ) && zero) || ((bt == BT_NE) && !zero);
    endfunction

endpackage

// File: rtl/branch_pc_if.sv
// Purpose: bundles the decode/flag-side controls and the fetch-side PC outputs.
// Latency: n/a (wires only).
// Backpressure: stall in, busy out; no buffering in the interface itself.
// Ports: master drives stall/zero/flag_write/branch_eq/branch_ne/jump/offset and
//        observes pc/pc_plus4/flush/busy; slave (the branch unit) is the reverse.
interface branch_pc_if;
    import branch_pc_unit_pkg::*;

    logic        stall;
    logic        zero;
    logic        flag_write;
    logic        branch_eq;
    logic        branch_ne;
    logic        jump;
    logic [31:0] offset;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        busy;

    modport master (
        output stall, zero, flag_write, branch_eq, branch_ne, jump, offset,
        input  pc, pc_plus4, flush, busy
    );

    modport slave (
        input  stall, zero, flag_write, branch_eq, branch_ne, jump, offset,
        output pc, pc_plus4, flush, busy
    );

endinterface

// File: rtl/branch_pc_unit_target_calc.sv
// Purpose: branch/jump target = pc_plus4 + (offset << OFFSET_SHIFT), 32-bit modulo.
// Latency: combinational.
// Backpressure: none.
// Ports: pc_plus4 (in 32), offset (in 32, word units, sign-extended), target (out 32).
module branch_pc_unit_target_calc
    import branch_pc_unit_pkg::*;
#(
    parameter int unsigned OFFSET_SHIFT = OFFSET_SHIFT_DEF
) (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] offset,
    output logic [31:0] target
);

    // Bits shifted out the top and the carry out of the add are dropped on
    // purpose: addresses wrap modulo 2^32.
    assign target = pc_plus4 + (offset << OFFSET_SHIFT);

endmodule

// File: rtl/branch_pc_unit.sv
// Purpose: owns the PC, resolves BEQ/BNE/J, waits out in-flight flag writes.
// Latency: redirect visible on pc 1 cycle after the branch; +1 per flag_write cycle.
// Backpressure: stall freezes pc in IDLE/REDIRECT; busy=1 asks upstream to hold.
// Ports: clk, reset_n (sync, active-low); bus (branch_pc_if.slave) carries the
//        controls in and pc/pc_plus4/flush/busy out.
module branch_pc_unit
    import branch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
    parameter int unsigned PC_STEP      = PC_STEP_DEF,
    parameter int unsigned OFFSET_SHIFT = OFFSET_SHIFT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    branch_pc_if.slave  bus
);

    state_t      state;
    logic [31:0] pc_q;
    logic        flush_q;
    logic        busy_q;
    bt_t         cap_bt;
    logic [31:0] cap_offset;

    logic [31:0] pc_plus4;
    logic [31:0] calc_offset;
    logic [31:0] target;
    bt_t         live_bt;

    assign pc_plus4 = pc_q + 32'(PC_STEP);
    assign live_bt  = decode_bt(bus.branch_eq, bus.branch_ne);

    // The PC is held while waiting on the flag, so pc_plus4 is still the one
    // belonging to the captured branch; only the offset has to come from the
    // capture register.
    assign calc_offset = (state == WAIT_FLAG) ? cap_offset : bus.offset;

    branch_pc_unit_target_calc #(
        .OFFSET_SHIFT (OFFSET_SHIFT)
    ) u_target_calc (
        .pc_plus4 (pc_plus4),
        .offset   (calc_offset),
        .target   (target)
    );

    // flush/busy are registered alongside the state so they always equal
    // (state==REDIRECT) and (state==WAIT_FLAG) without decode glitches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            busy_q     <= 1'b0;
            cap_bt     <= BT_NONE;
            cap_offset <= '0;
        end else begin
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.stall) begin
                        if (bus.jump) begin
                            pc_q    <= target;
                            state   <= REDIRECT;
                            flush_q <= 1'b1;
                        end else if ((live_bt != BT_NONE) && bus.flag_write) begin
                            // zero is stale this cycle: park the branch.
                            cap_bt     <= live_bt;
                            cap_offset <= bus.offset;
                            state      <= WAIT_FLAG;
                            busy_q     <= 1'b1;
                        end else if (branch_taken(live_bt, bus.zero)) begin
                            pc_q    <= target;
                            state   <= REDIRECT;
                            flush_q <= 1'b1;
                        end else begin
                            pc_q <= pc_plus4;
                        end
                    end
                end
                WAIT_FLAG: begin
                    if (bus.flag_write) begin
                        busy_q <= 1'b1;
                    end else if (branch_taken(cap_bt, bus.zero)) begin
                        pc_q    <= target;
                        state   <= REDIRECT;
                        flush_q <= 1'b1;
                    end else begin
                        pc_q  <= pc_plus4;
                        state <= IDLE;
                    end
                end
                REDIRECT: begin
                    // The instruction presented now is the squashed one, so its
                    // controls are ignored; only stall matters.
                    if (!bus.stall) begin
                        pc_q <= pc_plus4;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.flush    = flush_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Purpose: directed self-checking bench for branch_pc_unit.
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_pc_unit;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    branch_pc_if bus();

    branch_pc_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        bus.stall      = 1'b0;
        bus.zero       = 1'b0;
        bus.flag_write = 1'b0;
        bus.branch_eq  = 1'b0;
        bus.branch_ne  = 1'b0;
        bus.jump       = 1'b0;
        bus.offset     = 32'd0;
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        clear_ctl();
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Reset then free-run n cycles, giving pc = 4*n.
    task automatic goto_pc(input int n);
        reset_dut();
        repeat (n) step();
    endtask

    task automatic check_st(input string tag, input logic [31:0] pc_exp,
                            input logic flush_exp, input logic busy_exp);
        check({tag, "_pc"},    bus.pc,           pc_exp);
        check({tag, "_flush"}, 32'(bus.flush),   32'(flush_exp));
        check({tag, "_busy"},  32'(bus.busy),    32'(busy_exp));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // 1: reset and free-run
        reset_dut();
        check_st("rst", 32'd0, 1'b0, 1'b0);
        step(); check("run1", bus.pc, 32'd4);
        step(); check("run2", bus.pc, 32'd8);
        step(); check("run3", bus.pc, 32'd12);

        // 2: BEQ taken at pc=8, offset 3 -> 12 + 12 = 24
        goto_pc(2);
        check("beq_pc8", bus.pc, 32'd8);
        bus.branch_eq = 1'b1; bus.zero = 1'b1; bus.offset = 32'd3;
        #1 check("beq_plus4", bus.pc_plus4, 32'd12);
        step(); check_st("beq_tgt", 32'd24, 1'b1, 1'b0);
        clear_ctl();
        step(); check_st("beq_after", 32'd28, 1'b0, 1'b0);

        // 3: BNE with zero=1 -> not taken
        goto_pc(2);
        bus.branch_ne = 1'b1; bus.zero = 1'b1; bus.offset = 32'd3;
        step(); check_st("bne_nt", 32'd12, 1'b0, 1'b0);
        clear_ctl();
        step(); check_st("bne_after", 32'd16, 1'b0, 1'b0);

        // 4: BEQ at 16 with flag in flight, offset -2 -> 20 - 8 = 12.
        // Live controls during WAIT_FLAG are junk and must be ignored.
        goto_pc(4);
        bus.branch_eq = 1'b1; bus.flag_write = 1'b1; bus.offset = -32'sd2;
        step(); check_st("wf_wait", 32'd16, 1'b0, 1'b1);
        bus.flag_write = 1'b0; bus.zero = 1'b1;
        bus.branch_eq = 1'b0; bus.branch_ne = 1'b1; bus.jump = 1'b1;
        bus.stall = 1'b1; bus.offset = 32'd100;
        step(); check_st("wf_tgt", 32'd12, 1'b1, 1'b0);
        clear_ctl();
        step(); check_st("wf_after", 32'd16, 1'b0, 1'b0);

        // 4b: BNE waits two flag_write cycles, then not taken
        goto_pc(4);
        bus.branch_ne = 1'b1; bus.flag_write = 1'b1; bus.offset = 32'd5;
        step(); check_st("wf2_a", 32'd16, 1'b0, 1'b1);
        step(); check_st("wf2_b", 32'd16, 1'b0, 1'b1);
        bus.flag_write = 1'b0; bus.zero = 1'b1;
        step(); check_st("wf2_nt", 32'd20, 1'b0, 1'b0);
        clear_ctl();

        // 5: JUMP beats BEQ; 36 + (-9*4) = 0
        goto_pc(8);
        check("jmp_pc32", bus.pc, 32'd32);
        bus.jump = 1'b1; bus.branch_eq = 1'b1; bus.zero = 1'b0;
        bus.offset = -32'sd9;
        step(); check_st("jmp_tgt", 32'd0, 1'b1, 1'b0);
        clear_ctl();
        step(); check_st("jmp_after", 32'd4, 1'b0, 1'b0);

        // 5b: illegal BEQ+BNE is not-taken even with zero=1
        goto_pc(1);
        bus.branch_eq = 1'b1; bus.branch_ne = 1'b1; bus.zero = 1'b1;
        bus.offset = 32'd5;
        step(); check_st("illegal", 32'd8, 1'b0, 1'b0);
        clear_ctl();

        // 5c: reach 0xFFFF_FFFC with a jump (4 + (-2*4)), hold through REDIRECT
        // with stall, then wrap by a plain free-run increment.
        reset_dut();
        bus.jump = 1'b1; bus.offset = -32'sd2;
        step(); check_st("wrap_tgt", 32'hFFFF_FFFC, 1'b1, 1'b0);
        clear_ctl();
        bus.stall = 1'b1;
        step(); check_st("wrap_hold", 32'hFFFF_FFFC, 1'b0, 1'b0);
        check("wrap_plus4", bus.pc_plus4, 32'd0);
        bus.stall = 1'b0;
        step(); check_st("wrap_zero", 32'd0, 1'b0, 1'b0);

        // 6: reset during WAIT_FLAG discards the captured branch
        goto_pc(4);
        bus.branch_eq = 1'b1; bus.flag_write = 1'b1; bus.offset = 32'd7;
        step(); check_st("rwf_wait", 32'd16, 1'b0, 1'b1);
        reset_n = 1'b0;
        step(); check_st("rwf_rst", 32'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        clear_ctl();
        bus.zero = 1'b1;
        step(); check_st("rwf_after", 32'd4, 1'b0, 1'b0);

        // 6b: stall during REDIRECT, then IDLE stall ignores a jump
        goto_pc(2);
        bus.branch_eq = 1'b1; bus.zero = 1'b1; bus.offset = 32'd3;
        step(); check_st("rs_tgt", 32'd24, 1'b1, 1'b0);
        clear_ctl();
        bus.stall = 1'b1;
        step(); check_st("rs_hold", 32'd24, 1'b0, 1'b0);
        bus.jump = 1'b1; bus.offset = 32'd50;
        step(); check_st("rs_idle", 32'd24, 1'b0, 1'b0);
        clear_ctl();
        step(); check_st("rs_go", 32'd28, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
